// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 4x4 keypad row scanner with per-key debounce
//
// Purpose: drives one keypad row low at a time and samples the columns once per
// row period. Each of the 16 keys is debounced on its own, and a one-clock pulse
// marks every debounced press.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   col[3:0]   - column lines (pulled up; 0 = closed key in the active row)
//   row[3:0]   - row drive, active-low, exactly one bit low
//   btn[15:0]  - debounced key level, 1 = held, key k = row_index*4 + col_index
//   btn_press  - one-clock pulse per key on a debounced 0->1 transition
//   frame_tick - one-clock pulse registered with the row-3 sample strobe

module keypad_scan_debounce #(
    parameter int SCAN_DIV   = 2500,
    parameter int DEB_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] btn,
    output logic [15:0] btn_press,
    output logic        frame_tick
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_FRAMES);

    logic [DW-1:0] r_div;
    logic [1:0]    r_row_idx;
    logic [3:0]    r_col_m;
    logic [3:0]    r_col_s;
    logic          r_frame_tick;
    logic          w_strobe;

    // The strobe falls on the last clock of each row period, so the two-flop
    // synchronizer has settled on the new row's columns long before it.
    assign w_strobe = (r_div == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div        <= '0;
            r_row_idx    <= 2'd0;
            r_col_m      <= 4'b1111;
            r_col_s      <= 4'b1111;
            r_frame_tick <= 1'b0;
        end else begin
            r_col_m      <= col;
            r_col_s      <= r_col_m;
            r_frame_tick <= w_strobe && (r_row_idx == 2'd3);
            if (w_strobe) begin
                r_div     <= '0;
                r_row_idx <= r_row_idx + 2'd1;
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign row        = ~(4'b0001 << r_row_idx);
    assign frame_tick = r_frame_tick;

    // One debounce engine per key; a key only updates on the strobe of its row.
    for (genvar k = 0; k < 16; k++) begin : g_key
        logic [CW-1:0] r_cnt;
        logic          r_btn;
        logic          r_press;
        logic          w_sel;
        logic          w_raw;

        assign w_sel = w_strobe && (r_row_idx == 2'(k / 4));
        assign w_raw = ~r_col_s[k % 4];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt   <= '0;
                r_btn   <= 1'b0;
                r_press <= 1'b0;
            end else begin
                r_press <= 1'b0;
                if (w_sel) begin
                    if (w_raw == r_btn) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(DEB_FRAMES - 1)) begin
                        r_btn   <= w_raw;
                        r_cnt   <= '0;
                        r_press <= w_raw;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end

        assign btn[k]       = r_btn;
        assign btn_press[k] = r_press;
    end

endmodule
